// File: rtl/flit_replay_scheduler_pkg.sv
// ============================================================================
// Module      : flit_replay_pkg
// Description : Shared types and widths for the flit replay scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flit_replay_pkg;

    localparam int TIMEOUT_CNT_W = 11;
    localparam int REPLAY_NUM_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        REPLAY  = 2'd2,
        RETRAIN = 2'd3
    } replay_state_e;

endpackage

`default_nettype wire

// File: rtl/flit_replay_scheduler_if.sv
// ============================================================================
// Module      : flit_replay_scheduler_if
// Description : Handshake bundle between link layer and the replay scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flit_replay_scheduler_if #(
    parameter int PTR_W = 8
);
    import flit_replay_pkg::*;

    logic                     ack;
    logic                     nak;
    logic [TIMEOUT_CNT_W-1:0] timeout_count;
    logic                     retry_buf_not_empty;
    logic [PTR_W:0]           retry_buf_occupancy;
    logic                     tx_grant;
    logic                     flit_sent;
    logic                     retrain_done;
    logic                     replay_req;
    logic                     replay_active;
    logic [PTR_W-1:0]         replay_rd_idx;
    logic                     timeout_clr;
    logic [REPLAY_NUM_W-1:0]  replay_num;
    logic                     retrain_req;

    // Link-layer side: drives events, observes scheduler decisions
    modport master (
        output ack, nak, timeout_count, retry_buf_not_empty, retry_buf_occupancy,
               tx_grant, flit_sent, retrain_done,
        input  replay_req, replay_active, replay_rd_idx, timeout_clr,
               replay_num, retrain_req
    );

    modport slave (
        input  ack, nak, timeout_count, retry_buf_not_empty, retry_buf_occupancy,
               tx_grant, flit_sent, retrain_done,
        output replay_req, replay_active, replay_rd_idx, timeout_clr,
               replay_num, retrain_req
    );

endinterface

`default_nettype wire

// File: rtl/flit_replay_scheduler_replay_num_tracker.sv
// ============================================================================
// Module      : replay_num_tracker
// Description : Saturating consecutive-replay counter with clear and terminal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module replay_num_tracker
    import flit_replay_pkg::*;
#(
    parameter logic [REPLAY_NUM_W-1:0] MAX_REPLAY = 2'd3
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_clr,
    input  wire logic                    i_inc,
    output logic      [REPLAY_NUM_W-1:0] o_num,
    output logic                         o_terminal
);

    logic [REPLAY_NUM_W-1:0] r_num;

    // Clear takes effect before increment, so a same-cycle pair lands on 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
        end else if (i_clr && i_inc) begin
            r_num <= REPLAY_NUM_W'(1);
        end else if (i_clr) begin
            r_num <= '0;
        end else if (i_inc && (r_num != MAX_REPLAY)) begin
            r_num <= r_num + REPLAY_NUM_W'(1);
        end
    end

    assign o_num      = r_num;
    assign o_terminal = (r_num == MAX_REPLAY);

endmodule

`default_nettype wire

// File: rtl/flit_replay_scheduler.sv
// ============================================================================
// Module      : flit_replay_scheduler
// Description : Flit-mode TX replay sequencer with retrain escalation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_replay_scheduler
    import flit_replay_pkg::*;
#(
    parameter int                          PTR_W          = 8,
    parameter logic [TIMEOUT_CNT_W-1:0]    TIMEOUT_THRESH = 11'd384,
    parameter logic [REPLAY_NUM_W-1:0]     MAX_REPLAY     = 2'd3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    flit_replay_scheduler_if.slave  bus_if
);

    replay_state_e           r_state;
    replay_state_e           w_state_nxt;
    logic                    r_replay_req;
    logic                    w_replay_req_nxt;
    logic                    r_replay_active;
    logic                    w_replay_active_nxt;
    logic                    r_timeout_clr;
    logic                    w_timeout_clr_nxt;
    logic                    r_retrain_req;
    logic                    w_retrain_req_nxt;
    logic [PTR_W-1:0]        r_rd_idx;
    logic [PTR_W-1:0]        w_rd_idx_nxt;
    logic [PTR_W:0]          r_replay_len;
    logic [PTR_W:0]          w_replay_len_nxt;

    logic                    w_trig;
    logic                    w_occ_zero;
    logic                    w_escalate;
    logic                    w_num_clr;
    logic                    w_num_inc;
    logic                    w_num_terminal;
    logic [REPLAY_NUM_W-1:0] w_num;
    logic [PTR_W:0]          w_last_idx;

    assign w_trig     = bus_if.nak ||
                        (bus_if.retry_buf_not_empty && (bus_if.timeout_count >= TIMEOUT_THRESH));
    assign w_occ_zero = (bus_if.retry_buf_occupancy == '0);
    // A same-cycle ack resets progress first, so it also cancels escalation
    assign w_escalate = (r_state == IDLE) && w_trig && !w_occ_zero &&
                        !bus_if.ack && w_num_terminal;
    assign w_num_inc  = (r_state == IDLE) && w_trig && !w_occ_zero && !w_escalate;
    assign w_num_clr  = ((r_state != RETRAIN) && bus_if.ack) ||
                        ((r_state == RETRAIN) && bus_if.retrain_done);
    assign w_last_idx = r_replay_len - (PTR_W+1)'(1);

    replay_num_tracker #(
        .MAX_REPLAY (MAX_REPLAY)
    ) u_num (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_num_clr),
        .i_inc      (w_num_inc),
        .o_num      (w_num),
        .o_terminal (w_num_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_replay_req    <= 1'b0;
            r_replay_active <= 1'b0;
            r_timeout_clr   <= 1'b0;
            r_retrain_req   <= 1'b0;
            r_rd_idx        <= '0;
            r_replay_len    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_replay_req    <= w_replay_req_nxt;
            r_replay_active <= w_replay_active_nxt;
            r_timeout_clr   <= w_timeout_clr_nxt;
            r_retrain_req   <= w_retrain_req_nxt;
            r_rd_idx        <= w_rd_idx_nxt;
            r_replay_len    <= w_replay_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_replay_req_nxt    = r_replay_req;
        w_replay_active_nxt = r_replay_active;
        w_timeout_clr_nxt   = 1'b0;
        w_retrain_req_nxt   = r_retrain_req;
        w_rd_idx_nxt        = r_rd_idx;
        w_replay_len_nxt    = r_replay_len;

        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_timeout_clr_nxt = 1'b1;
                    if (w_escalate) begin
                        w_state_nxt       = RETRAIN;
                        w_retrain_req_nxt = 1'b1;
                    end else if (!w_occ_zero) begin
                        w_state_nxt      = REQ;
                        w_replay_req_nxt = 1'b1;
                        w_replay_len_nxt = bus_if.retry_buf_occupancy;
                        w_rd_idx_nxt     = '0;
                    end
                end
            end
            REQ: begin
                if (bus_if.tx_grant) begin
                    w_state_nxt         = REPLAY;
                    w_replay_req_nxt    = 1'b0;
                    w_replay_active_nxt = 1'b1;
                end
            end
            REPLAY: begin
                // Full-buffer replays wrap the index only on the final flit
                if (bus_if.flit_sent) begin
                    if ({1'b0, r_rd_idx} == w_last_idx) begin
                        w_state_nxt         = IDLE;
                        w_replay_active_nxt = 1'b0;
                        w_rd_idx_nxt        = '0;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + PTR_W'(1);
                    end
                end
            end
            RETRAIN: begin
                if (bus_if.retrain_done) begin
                    w_state_nxt       = IDLE;
                    w_retrain_req_nxt = 1'b0;
                    w_timeout_clr_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus_if.replay_req    = r_replay_req;
    assign bus_if.replay_active = r_replay_active;
    assign bus_if.replay_rd_idx = r_rd_idx;
    assign bus_if.timeout_clr   = r_timeout_clr;
    assign bus_if.replay_num    = w_num;
    assign bus_if.retrain_req   = r_retrain_req;

endmodule

`default_nettype wire

// File: tb/tb_flit_replay_scheduler.sv
// ============================================================================
// Module      : tb_flit_replay_scheduler
// Description : Randomized self-checking bench for the flit replay scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flit_replay_scheduler;

    localparam int PW   = 3;
    localparam int MAXR = 3;
    localparam int TH   = 384;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   m_num;

    flit_replay_scheduler_if #(.PTR_W(PW)) bus();

    flit_replay_scheduler #(
        .PTR_W          (PW),
        .TIMEOUT_THRESH (11'd384),
        .MAX_REPLAY     (2'd3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ack = 1'b0; bus.nak = 1'b0; bus.timeout_count = '0;
        bus.tx_grant = 1'b0; bus.flit_sent = 1'b0; bus.retrain_done = 1'b0;
    endtask

    // Applies one trigger and follows whatever outcome the reference rules predict
    task automatic trigger_and_check(input bit use_nak, input bit with_ack, input int occ,
                                     input int gdelay, input bit noise, input int tval);
        int  exp_num;
        int  outcome; // 0 empty, 1 retrain, 2 replay
        int  gap;
        exp_num = with_ack ? 0 : m_num;
        if (occ == 0)              outcome = 0;
        else if (exp_num == MAXR)  outcome = 1;
        else begin outcome = 2; exp_num = exp_num + 1; end

        bus.retry_buf_occupancy = 4'(occ);
        bus.retry_buf_not_empty = (occ != 0);
        bus.ack = with_ack;
        if (use_nak) bus.nak = 1'b1;
        else         bus.timeout_count = 11'(tval);
        tick;
        idle_inputs();
        m_num = exp_num;

        checks++; if (bus.timeout_clr !== 1'b1) begin failures++;
            $display("FAIL trig_timeout_clr got=%0b exp=1", bus.timeout_clr); end
        checks++; if (bus.replay_num !== 2'(exp_num)) begin failures++;
            $display("FAIL trig_replay_num got=%0d exp=%0d", bus.replay_num, exp_num); end
        checks++; if (bus.replay_req !== (outcome == 2)) begin failures++;
            $display("FAIL trig_replay_req got=%0b exp=%0b", bus.replay_req, outcome == 2); end
        checks++; if (bus.retrain_req !== (outcome == 1)) begin failures++;
            $display("FAIL trig_retrain_req got=%0b exp=%0b", bus.retrain_req, outcome == 1); end

        if (outcome == 0) begin
            tick;
            checks++; if (bus.timeout_clr !== 1'b0 || bus.replay_req !== 1'b0 ||
                          bus.replay_num !== 2'(m_num)) begin failures++;
                $display("FAIL empty_after clr=%0b req=%0b num=%0d exp 0/0/%0d",
                         bus.timeout_clr, bus.replay_req, bus.replay_num, m_num); end
        end else if (outcome == 1) begin
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
                if (noise) begin bus.ack = 1'($urandom); bus.nak = 1'($urandom); end
                tick;
                checks++; if (bus.retrain_req !== 1'b1 || bus.replay_req !== 1'b0 ||
                              bus.timeout_clr !== 1'b0 || bus.replay_num !== 2'(MAXR)) begin
                    failures++;
                    $display("FAIL retrain_hold rreq=%0b req=%0b clr=%0b num=%0d exp 1/0/0/3",
                             bus.retrain_req, bus.replay_req, bus.timeout_clr, bus.replay_num);
                end
            end
            idle_inputs();
            bus.retrain_done = 1'b1;
            tick;
            bus.retrain_done = 1'b0;
            m_num = 0;
            checks++; if (bus.retrain_req !== 1'b0 || bus.replay_num !== 2'd0 ||
                          bus.timeout_clr !== 1'b1) begin failures++;
                $display("FAIL retrain_done rreq=%0b num=%0d clr=%0b exp 0/0/1",
                         bus.retrain_req, bus.replay_num, bus.timeout_clr); end
            tick;
            checks++; if (bus.timeout_clr !== 1'b0 || bus.replay_req !== 1'b0) begin failures++;
                $display("FAIL retrain_exit clr=%0b req=%0b exp 0/0", bus.timeout_clr, bus.replay_req); end
        end else begin
            for (int i = 0; i < gdelay; i++) begin
                if (noise) begin
                    bus.nak = 1'($urandom);
                    bus.ack = 1'($urandom);
                    bus.timeout_count = 11'(TH + $urandom_range(0, 500));
                    if (bus.ack) m_num = 0;
                end
                tick;
                idle_inputs();
                checks++; if (bus.replay_req !== 1'b1 || bus.replay_active !== 1'b0 ||
                              bus.timeout_clr !== 1'b0) begin failures++;
                    $display("FAIL req_hold req=%0b act=%0b clr=%0b exp 1/0/0",
                             bus.replay_req, bus.replay_active, bus.timeout_clr); end
            end
            bus.tx_grant = 1'b1;
            tick;
            bus.tx_grant = 1'b0;
            checks++; if (bus.replay_req !== 1'b0 || bus.replay_active !== 1'b1 ||
                          bus.replay_rd_idx !== '0) begin failures++;
                $display("FAIL grant req=%0b act=%0b idx=%0d exp 0/1/0",
                         bus.replay_req, bus.replay_active, bus.replay_rd_idx); end
            for (int k = 0; k < occ; k++) begin
                gap = noise ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < gap; g++) begin
                    bus.nak = 1'($urandom);
                    bus.ack = 1'($urandom);
                    if (bus.ack) m_num = 0;
                    tick;
                    idle_inputs();
                end
                checks++; if (bus.replay_rd_idx !== PW'(k) || bus.replay_active !== 1'b1) begin
                    failures++;
                    $display("FAIL replay_idx got=%0d act=%0b exp=%0d/1",
                             bus.replay_rd_idx, bus.replay_active, k); end
                bus.flit_sent = 1'b1;
                tick;
                bus.flit_sent = 1'b0;
            end
            checks++; if (bus.replay_active !== 1'b0 || bus.replay_rd_idx !== '0 ||
                          bus.replay_num !== 2'(m_num)) begin failures++;
                $display("FAIL replay_end act=%0b idx=%0d num=%0d exp 0/0/%0d",
                         bus.replay_active, bus.replay_rd_idx, bus.replay_num, m_num); end
            bus.flit_sent = 1'b1;
            tick;
            bus.flit_sent = 1'b0;
            checks++; if (bus.replay_rd_idx !== '0 || bus.replay_active !== 1'b0 ||
                          bus.replay_req !== 1'b0) begin failures++;
                $display("FAIL stray_flit idx=%0d act=%0b req=%0b exp 0/0/0",
                         bus.replay_rd_idx, bus.replay_active, bus.replay_req); end
        end
    endtask

    task automatic clear_num;
        bus.ack = 1'b1;
        tick;
        bus.ack = 1'b0;
        m_num = 0;
        checks++; if (bus.replay_num !== 2'd0) begin failures++;
            $display("FAIL ack_clear got=%0d exp=0", bus.replay_num); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        bus.retry_buf_not_empty = 1'b0;
        bus.retry_buf_occupancy = '0;
        repeat (3) tick;
        checks++; if (bus.replay_req !== 1'b0 || bus.replay_active !== 1'b0 ||
                      bus.timeout_clr !== 1'b0 || bus.retrain_req !== 1'b0 ||
                      bus.replay_rd_idx !== '0 || bus.replay_num !== 2'd0) begin failures++;
            $display("FAIL reset_state req=%0b act=%0b clr=%0b rreq=%0b idx=%0d num=%0d exp all 0",
                     bus.replay_req, bus.replay_active, bus.timeout_clr, bus.retrain_req,
                     bus.replay_rd_idx, bus.replay_num); end
        rst_n = 1'b1;
        m_num = 0;
        tick;
    endtask

    task automatic test_timeout_trigger;
        bus.retry_buf_occupancy = 4'd5;
        bus.retry_buf_not_empty = 1'b0;
        bus.timeout_count = 11'd2000;
        tick;
        checks++; if (bus.timeout_clr !== 1'b0 || bus.replay_req !== 1'b0) begin failures++;
            $display("FAIL timeout_empty_flag clr=%0b req=%0b exp 0/0", bus.timeout_clr, bus.replay_req); end
        bus.retry_buf_not_empty = 1'b1;
        for (int v = 380; v < TH; v++) begin
            bus.timeout_count = 11'(v);
            tick;
            checks++; if (bus.timeout_clr !== 1'b0 || bus.replay_req !== 1'b0) begin failures++;
                $display("FAIL below_thresh count=%0d clr=%0b req=%0b exp 0/0",
                         v, bus.timeout_clr, bus.replay_req); end
        end
        trigger_and_check(1'b0, 1'b0, 5, 3, 1'b0, TH);
        checks++; if (bus.replay_num !== 2'd1) begin failures++;
            $display("FAIL timeout_num got=%0d exp=1", bus.replay_num); end
    endtask

    task automatic test_nak_grant_delay;
        clear_num();
        trigger_and_check(1'b1, 1'b0, 3, 7, 1'b0, 0);
        trigger_and_check(1'b1, 1'b1, 3, 2, 1'b1, 0);
    endtask

    task automatic test_escalation;
        clear_num();
        for (int i = 0; i < 3; i++)
            trigger_and_check(1'b1, 1'b0, 2, int'($urandom_range(0, 3)), 1'b0, 0);
        checks++; if (bus.replay_num !== 2'd3) begin failures++;
            $display("FAIL escalate_num got=%0d exp=3", bus.replay_num); end
        trigger_and_check(1'b1, 1'b0, 2, 0, 1'b1, 0);
    endtask

    task automatic test_ack_nak_same_cycle;
        clear_num();
        trigger_and_check(1'b1, 1'b0, 3, 1, 1'b0, 0);
        trigger_and_check(1'b1, 1'b0, 3, 1, 1'b0, 0);
        trigger_and_check(1'b1, 1'b1, 3, 1, 1'b0, 0);
        trigger_and_check(1'b1, 1'b0, 4, 0, 1'b0, 0);
        trigger_and_check(1'b1, 1'b0, 4, 0, 1'b0, 0);
        trigger_and_check(1'b1, 1'b1, 4, 2, 1'b0, 0);
    endtask

    task automatic test_empty_nak;
        trigger_and_check(1'b1, 1'b0, 0, 0, 1'b0, 0);
        trigger_and_check(1'b1, 1'b1, 0, 0, 1'b0, 0);
    endtask

    task automatic test_full_and_reset;
        clear_num();
        trigger_and_check(1'b1, 1'b0, 8, 2, 1'b0, 0);
        bus.retry_buf_occupancy = 4'd8;
        bus.retry_buf_not_empty = 1'b1;
        bus.nak = 1'b1;
        tick;
        bus.nak = 1'b0;
        bus.tx_grant = 1'b1;
        tick;
        bus.tx_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.flit_sent = 1'b1;
            tick;
        end
        bus.flit_sent = 1'b0;
        checks++; if (bus.replay_rd_idx !== 3'd4 || bus.replay_active !== 1'b1 ||
                      bus.replay_num !== 2'd2) begin failures++;
            $display("FAIL pre_reset idx=%0d act=%0b num=%0d exp 4/1/2",
                     bus.replay_rd_idx, bus.replay_active, bus.replay_num); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.replay_req !== 1'b0 || bus.replay_active !== 1'b0 ||
                      bus.timeout_clr !== 1'b0 || bus.retrain_req !== 1'b0 ||
                      bus.replay_rd_idx !== '0 || bus.replay_num !== 2'd0) begin failures++;
            $display("FAIL async_reset req=%0b act=%0b clr=%0b rreq=%0b idx=%0d num=%0d exp all 0",
                     bus.replay_req, bus.replay_active, bus.timeout_clr, bus.retrain_req,
                     bus.replay_rd_idx, bus.replay_num); end
        tick;
        rst_n = 1'b1;
        m_num = 0;
        tick;
    endtask

    task automatic test_random;
        bit use_nak;
        int occ;
        for (int n = 0; n < 30; n++) begin
            use_nak = 1'($urandom);
            occ     = int'($urandom_range(0, 8));
            if (occ == 0) use_nak = 1'b1;
            trigger_and_check(use_nak, ($urandom_range(0, 3) == 0), occ,
                              int'($urandom_range(0, 4)), 1'b1,
                              TH + int'($urandom_range(0, 1663)));
            repeat ($urandom_range(0, 2)) tick;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_num    = 0;
        test_reset();
        test_timeout_trigger();
        test_nak_grant_delay();
        test_escalation();
        test_ack_nak_same_cycle();
        test_empty_nak();
        test_full_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/flit_replay_scheduler.md
Name: flit_replay_scheduler

Overview:
- Sequences flit-mode replay on the TX side.
- Watches the replay timeout flit count and NAKs, and decides when a replay starts.
- Arbitrates the replay stream onto the TX flit path and walks the TX retry buffer index during replay.
- Counts consecutive replays (REPLAY_NUM) and escalates to a link retrain request after too many replays without forward progress.

Parameters:
- PTR_W, 8, width of the retry buffer index; buffer depth is 2**PTR_W flits.
- TIMEOUT_THRESH, 11'd384, timeout flit count at or above which a replay is triggered.
- MAX_REPLAY, 2'd3, REPLAY_NUM value at which the next trigger escalates to retrain.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ack  in  1  ACK received; purges the retry buffer and shows forward progress
- nak  in  1  NAK received; requests a replay
- timeout_count  in  11  REPLAY_TIMEOUT_FLIT_COUNT from the timeout counter
- retry_buf_not_empty  in  1  TX retry buffer holds unacked flits
- retry_buf_occupancy  in  PTR_W+1  number of flits held in the retry buffer
- tx_grant  in  1  TX arbiter grants the replay stream
- flit_sent  in  1  one replayed flit accepted by TX this cycle
- retrain_done  in  1  LTSSM finished the retrain
- replay_req  out  1  request to the TX arbiter
- replay_active  out  1  replay stream owns TX
- replay_rd_idx  out  PTR_W  offset from the oldest unacked flit
- timeout_clr  out  1  one-cycle clear pulse to the timeout counter
- replay_num  out  2  consecutive replay count
- retrain_req  out  1  request link retrain

Behaviour:
- Reset: state IDLE. replay_req, replay_active, timeout_clr and retrain_req are 0. replay_rd_idx = 0, replay_num = 0, internal replay_len = 0.
- States: IDLE, REQ, REPLAY, RETRAIN.
- Trigger is evaluated in IDLE only: trig = nak || (retry_buf_not_empty && timeout_count >= TIMEOUT_THRESH).
- ack in any state, except RETRAIN, clears replay_num to 0 next cycle.
- ack and trig in the same IDLE cycle: ack clears replay_num first, then trig applies, so the result is replay_num = 1.
- IDLE on trig, occupancy == 0: pulse timeout_clr and stay IDLE; replay_num is unchanged.
- IDLE on trig, occupancy != 0, replay_num == MAX_REPLAY: pulse timeout_clr, go RETRAIN, assert retrain_req.
- IDLE on trig, otherwise:
  - pulse timeout_clr;
  - replay_num += 1;
  - latch replay_len = occupancy;
  - replay_rd_idx = 0;
  - go REQ.
- REQ: replay_req = 1 and held until tx_grant. On tx_grant go REPLAY next cycle with replay_req = 0 and replay_active = 1. Grant latency is unbounded.
- REPLAY:
  - replay_active = 1.
  - Each flit_sent advances replay_rd_idx by 1.
  - flit_sent with replay_rd_idx == replay_len-1 returns to IDLE next cycle with replay_active = 0 and replay_rd_idx = 0.
  - Total flits sent equals replay_len exactly.
  - Full buffer: replay_len = 2**PTR_W; the index wraps only at the final flit, which is legal.
- nak, and timeouts reaching threshold, during REQ or REPLAY are ignored; there is no queued trigger. After return to IDLE, trig is re-evaluated from live inputs.
- ack during REPLAY does not abort the replay; it only clears replay_num.
- RETRAIN:
  - retrain_req = 1 until retrain_done.
  - On retrain_done: replay_num = 0, retrain_req = 0, pulse timeout_clr, go IDLE.
  - ack and nak are ignored in this state.
- timeout_clr is a registered single-cycle pulse, asserted the cycle after the triggering decision. replay_req and replay_active are registered with no combinational input-to-output path.
- replay_num never exceeds MAX_REPLAY.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Shared package flit_replay_pkg holds:
  - the state enum typedef replay_state_e (IDLE, REQ, REPLAY, RETRAIN);
  - localparam TIMEOUT_CNT_W = 11;
  - REPLAY_NUM_W = 2.
- One sub-module, replay_num_tracker: the 2-bit saturating replay counter with ack-clear and a terminal flag, instantiated inside the scheduler.
- The FSM and the index walker stay in the top module.

Test Plan:
- Timeout trigger: occupancy=5, timeout_count ramps to 384 -> timeout_clr pulse once, replay_req until grant, exactly 5 flit_sent with replay_rd_idx 0..4, back to IDLE, replay_num=1.
- NAK with grant delay: nak, occupancy=3, tx_grant delayed 7 cycles -> replay_req held 7 cycles; a second nak during REPLAY is ignored; replay_num=1.
- Escalation: 4 NAK triggers with no ack, occupancy=2 -> replay_num reaches 3, then the 4th trigger asserts retrain_req with no replay. retrain_done -> replay_num=0, timeout_clr pulse.
- Simultaneous ack+nak in IDLE with replay_num=2 -> replay_num=1 and a replay starts.
- Empty-buffer nak: occupancy=0 -> timeout_clr pulse only, state stays IDLE, replay_num unchanged.
- Full buffer and reset: PTR_W=3, occupancy=8 -> replay_rd_idx 0..7, then 0. Assert rst_n low mid-REPLAY at idx 4 -> all outputs at reset values immediately.
